conv_layer_sched: RTL and testbench

Sequencer for one convolution layer. Drives the 3-bit `current_state` bus shared by the weight ROM cache, the input line cache and the MAC array. It steps each output window through preload/load, weight shift and bias phases for every kernel set, and tags accumulator results. It sits between the layer-level controller (`start`/`done`) and the conv datapath.

---
 rtl/conv_layer_sched_pkg.sv | 29 ++
 rtl/conv_layer_sched_if.sv | 58 +++++
 rtl/conv_layer_sched_phase_counter.sv | 29 ++
 rtl/conv_layer_sched.sv | 202 ++++++++++++++++++++
 tb/tb_conv_layer_sched.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_layer_sched_pkg.sv
// conv_layer_sched_pkg
//   Shared conv-kernel definitions. The weight ROM cache, the input line cache,
//   the MAC array and the layer scheduler all decode the 3-bit phase bus from
//   this package, so they cannot drift apart.
//   Contents:
//     phase_e          - phase codes carried on current_state
//     WEIGHT_ROM_DEPTH - weight ROM depth; bounds KERNEL_NUM*(KERNEL_SIZE^2+1)
//     idx_width()      - index width helper, never narrower than 1 bit
package conv_layer_sched_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_PRELOAD = 3'd1,
    PH_SHIFT   = 3'd2,
    PH_BIAS    = 3'd3,
    PH_LOAD    = 3'd4,
    PH_DONE    = 3'd5,
    PH_HOLD    = 3'd6
  } phase_e;

  localparam int WEIGHT_ROM_DEPTH = 64;

  // Bits needed to index n items. Returns 1 for n <= 1 so that no port
  // collapses to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_layer_sched_if.sv
// conv_layer_sched_if
//   Signal bundle between the layer controller / conv datapath and the
//   scheduler.
//   Modports:
//     master - scheduler side: takes start/hold_req and drives everything else
//     slave  - controller/datapath side
//   Signals: start, hold_req, current_state[2:0], kernel_idx, window_cnt,
//            acc_clear, result_valid, result_kernel, busy, done,
//            hold_cycles[15:0] (only when CONV_SCHED_PERF_EN is defined)
//
// Handshake: there is no ready signal. start is a one-cycle request that is
// sampled only while the scheduler is idle. hold_req is a level that is
// sampled only at the boundaries that would enter SHIFT. result_valid and
// done are single-cycle pulses that the consumer cannot stall.
interface conv_layer_sched_if
  import conv_layer_sched_pkg::*;
#(
  parameter int KERNEL_NUM = 2,
  parameter int OUT_WIDTH  = 4,
  parameter int OUT_HEIGHT = 4
) ();

  localparam int KW = idx_width(KERNEL_NUM);
  localparam int WW = idx_width(OUT_WIDTH * OUT_HEIGHT);

  logic          start;
  logic          hold_req;
  logic [2:0]    current_state;
  logic [KW-1:0] kernel_idx;
  logic [WW-1:0] window_cnt;
  logic          acc_clear;
  logic          result_valid;
  logic [KW-1:0] result_kernel;
  logic          busy;
  logic          done;
`ifdef CONV_SCHED_PERF_EN
  logic [15:0]   hold_cycles;
`endif

  modport master (
`ifdef CONV_SCHED_PERF_EN
    output hold_cycles,
`endif
    input  start, hold_req,
    output current_state, kernel_idx, window_cnt, acc_clear,
    output result_valid, result_kernel, busy, done
  );

  modport slave (
`ifdef CONV_SCHED_PERF_EN
    input  hold_cycles,
`endif
    output start, hold_req,
    input  current_state, kernel_idx, window_cnt, acc_clear,
    input  result_valid, result_kernel, busy, done
  );

endinterface

// File: rtl/conv_layer_sched_phase_counter.sv
// sched_phase_counter
//   Loadable down-counter that times the PRELOAD, SHIFT, LOAD and DONE
//   segments. A segment of N cycles is loaded with N-1 on entry, and tc is
//   high in its last cycle. The counter stops at zero.
//   Ports: clk, rst_n (async, active-low), load, load_val, count, tc
module sched_phase_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/conv_layer_sched.sv
// conv_layer_sched
//   Sequencer for one convolution layer. For each output window it runs
//   PRELOAD (window 0) or LOAD (later windows). It then runs SHIFT
//   (KERNEL_SIZE^2 cycles) and BIAS (1 cycle) once per kernel set. It pulses
//   acc_clear at the start of each kernel pass, tags accumulator results two
//   cycles after each BIAS, and finishes with a two-cycle DONE phase.
//   Ports: clk, rst_n (async, active-low), bus (conv_layer_sched_if.master).
//   Optional feature: CONV_SCHED_PERF_EN adds bus.hold_cycles, a saturating
//   count of HOLD cycles that is cleared when start is accepted.
//   current_state is the FSM state register itself, so it is visible for
//   debug without a separate port.
module conv_layer_sched
  import conv_layer_sched_pkg::*;
#(
  parameter int KERNEL_SIZE    = 3,
  parameter int KERNEL_NUM     = 2,
  parameter int OUT_WIDTH      = 4,
  parameter int OUT_HEIGHT     = 4,
  parameter int PRELOAD_CYCLES = 8,
  parameter int LOAD_CYCLES    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_layer_sched_if.master   bus
);

  localparam int KK  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NW  = OUT_WIDTH * OUT_HEIGHT;
  localparam int KW  = idx_width(KERNEL_NUM);
  localparam int WW  = idx_width(NW);
  localparam int SEG_A   = (PRELOAD_CYCLES > KK) ? PRELOAD_CYCLES : KK;
  localparam int SEG_B   = (SEG_A > LOAD_CYCLES) ? SEG_A : LOAD_CYCLES;
  localparam int MAX_SEG = (SEG_B > 2) ? SEG_B : 2;
  localparam int CW  = idx_width(MAX_SEG);

  localparam logic [CW-1:0] PRELOAD_LD = CW'(PRELOAD_CYCLES - 1);
  localparam logic [CW-1:0] SHIFT_LD   = CW'(KK - 1);
  localparam logic [CW-1:0] LOAD_LD    = CW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] DONE_LD    = CW'(1);
  localparam logic [KW-1:0] K_LAST     = KW'(KERNEL_NUM - 1);
  localparam logic [WW-1:0] W_LAST     = WW'(NW - 1);

  // Every kernel pass must fit in the weight ROM.
  if (KERNEL_NUM * (KK + 1) > WEIGHT_ROM_DEPTH) begin : g_rom_depth_check
    $fatal(1, "conv_layer_sched: KERNEL_NUM*(KERNEL_SIZE^2+1) exceeds weight ROM depth");
  end

  phase_e        state, nxt_state;
  logic [KW-1:0] kidx_q;
  logic [WW-1:0] win_q;
  logic          acc_clear_q;
  logic          pipe_v;
  logic [KW-1:0] pipe_k;
  logic          result_valid_q;
  logic [KW-1:0] result_kernel_q;
  logic          busy_q;
  logic          done_q;

  logic          ctr_load;
  logic [CW-1:0] ctr_val;
  logic [CW-1:0] ctr_count;
  logic          ctr_tc;

  sched_phase_counter #(.WIDTH(CW)) u_phase_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ctr_load),
    .load_val (ctr_val),
    .count    (ctr_count),
    .tc       (ctr_tc)
  );

  logic   last_kernel;
  logic   last_window;
  phase_e shift_target;

  assign last_kernel  = (kidx_q == K_LAST);
  assign last_window  = (win_q == W_LAST);
  // Any boundary that would enter SHIFT diverts to HOLD under back-pressure.
  assign shift_target = bus.hold_req ? PH_HOLD : PH_SHIFT;

  // Next phase and segment timer load. The SHIFT length is loaded even when
  // diverting to HOLD. That is harmless, because HOLD reloads it on exit.
  always_comb begin
    nxt_state = state;
    ctr_load  = 1'b0;
    ctr_val   = '0;
    case (state)
      PH_IDLE: begin
        if (bus.start) begin
          nxt_state = PH_PRELOAD;
          ctr_load  = 1'b1;
          ctr_val   = PRELOAD_LD;
        end
      end
      PH_PRELOAD, PH_LOAD: begin
        if (ctr_tc) begin
          nxt_state = shift_target;
          ctr_load  = 1'b1;
          ctr_val   = SHIFT_LD;
        end
      end
      PH_SHIFT: begin
        if (ctr_tc) nxt_state = PH_BIAS;
      end
      PH_BIAS: begin
        ctr_load = 1'b1;
        if (!last_kernel) begin
          nxt_state = shift_target;
          ctr_val   = SHIFT_LD;
        end else if (!last_window) begin
          nxt_state = PH_LOAD;
          ctr_val   = LOAD_LD;
        end else begin
          nxt_state = PH_DONE;
          ctr_val   = DONE_LD;
        end
      end
      PH_HOLD: begin
        if (!bus.hold_req) begin
          nxt_state = PH_SHIFT;
          ctr_load  = 1'b1;
          ctr_val   = SHIFT_LD;
        end
      end
      PH_DONE: begin
        if (ctr_tc) nxt_state = PH_IDLE;
      end
      default: nxt_state = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= PH_IDLE;
      kidx_q          <= '0;
      win_q           <= '0;
      acc_clear_q     <= 1'b0;
      pipe_v          <= 1'b0;
      pipe_k          <= '0;
      result_valid_q  <= 1'b0;
      result_kernel_q <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state       <= nxt_state;
      busy_q      <= (nxt_state != PH_IDLE);
      acc_clear_q <= (nxt_state == PH_SHIFT) && (state != PH_SHIFT);
      // The DONE timer starts at 1, so !tc marks the first DONE cycle and
      // done lands in the second.
      done_q      <= (state == PH_DONE) && !ctr_tc;

      // Result tag pipe: one stage for the weight-cache register and one
      // for the accumulator.
      pipe_v         <= (state == PH_BIAS);
      if (state == PH_BIAS) pipe_k <= kidx_q;
      result_valid_q  <= pipe_v;
      result_kernel_q <= pipe_k;

      if (state == PH_IDLE && bus.start) begin
        kidx_q <= '0;
        win_q  <= '0;
      end else if (state == PH_BIAS) begin
        if (!last_kernel) begin
          kidx_q <= kidx_q + 1'b1;
        end else if (!last_window) begin
          kidx_q <= '0;
          win_q  <= win_q + 1'b1;
        end
      end else if (state == PH_DONE && ctr_tc) begin
        kidx_q <= '0;
        win_q  <= '0;
      end
    end
  end

`ifdef CONV_SCHED_PERF_EN
  logic [15:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == PH_IDLE && bus.start) begin
      hold_cnt <= '0;
    end else if (state == PH_HOLD && hold_cnt != 16'hFFFF) begin
      hold_cnt <= hold_cnt + 16'd1;
    end
  end

  assign bus.hold_cycles = hold_cnt;
`endif

  assign bus.current_state = state;
  assign bus.kernel_idx    = kidx_q;
  assign bus.window_cnt    = win_q;
  assign bus.acc_clear     = acc_clear_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.result_kernel = result_kernel_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched
//   Directed sequence of layer runs for conv_layer_sched with random hold_req
//   and start noise. Each run is compared cycle by cycle against an expected
//   trace. The trace is built from the phase rules: segment lengths per
//   window and kernel, HOLD insertion at SHIFT entry boundaries, and result
//   tags two cycles after each BIAS. If CONV_SCHED_PERF_EN is defined, the
//   hold_cycles counter is checked as well.
module tb_conv_layer_sched;
  import conv_layer_sched_pkg::*;

  localparam int KERNEL_SIZE    = 3;
  localparam int KERNEL_NUM     = 2;
  localparam int OUT_WIDTH      = 4;
  localparam int OUT_HEIGHT     = 4;
  localparam int PRELOAD_CYCLES = 8;
  localparam int LOAD_CYCLES    = 3;
  localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NW   = OUT_WIDTH * OUT_HEIGHT;
  localparam int KW   = idx_width(KERNEL_NUM);
  localparam int WW   = idx_width(NW);
  localparam int MAXC = 2048;
  // First PRELOAD cycle to first DONE cycle with no holds.
  localparam int T_LAYER = PRELOAD_CYCLES + KERNEL_NUM * (KK + 1)
                         + (NW - 1) * (LOAD_CYCLES + KERNEL_NUM * (KK + 1));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_layer_sched_if #(
    .KERNEL_NUM (KERNEL_NUM),
    .OUT_WIDTH  (OUT_WIDTH),
    .OUT_HEIGHT (OUT_HEIGHT)
  ) bus_if ();

  conv_layer_sched #(
    .KERNEL_SIZE    (KERNEL_SIZE),
    .KERNEL_NUM     (KERNEL_NUM),
    .OUT_WIDTH      (OUT_WIDTH),
    .OUT_HEIGHT     (OUT_HEIGHT),
    .PRELOAD_CYCLES (PRELOAD_CYCLES),
    .LOAD_CYCLES    (LOAD_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [2:0]    st;
    logic [KW-1:0] kidx;
    logic [WW-1:0] win;
    logic          acc;
    logic          rv;
    logic [KW-1:0] rk;
    logic          done;
    logic          busy;
  } cyc_t;

  cyc_t exp_q[$];
  bit   hold_sched[MAXC];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void push(input phase_e st, input int k, input int w,
                               input bit acc, input bit dn);
    cyc_t e;
    e      = '0;
    e.st   = st;
    e.kidx = KW'(k);
    e.win  = WW'(w);
    e.acc  = acc;
    e.done = dn;
    e.busy = (st != PH_IDLE);
    exp_q.push_back(e);
  endfunction

  // Expected trace, cycle 0 = first PRELOAD cycle. hold_sched[c] is the
  // hold_req level sampled at the edge that ends cycle c.
  function automatic void build_model();
    cyc_t e;
    exp_q.delete();
    for (int i = 0; i < PRELOAD_CYCLES; i++) push(PH_PRELOAD, 0, 0, 0, 0);
    for (int w = 0; w < NW; w++) begin
      for (int k = 0; k < KERNEL_NUM; k++) begin
        if (w > 0 && k == 0)
          for (int i = 0; i < LOAD_CYCLES; i++) push(PH_LOAD, 0, w, 0, 0);
        while (exp_q.size() < MAXC - 1 && hold_sched[exp_q.size() - 1])
          push(PH_HOLD, k, w, 0, 0);
        for (int i = 0; i < KK; i++) push(PH_SHIFT, k, w, (i == 0), 0);
        push(PH_BIAS, k, w, 0, 0);
      end
    end
    push(PH_DONE, KERNEL_NUM - 1, NW - 1, 0, 0);
    push(PH_DONE, KERNEL_NUM - 1, NW - 1, 0, 1);
    for (int i = 0; i < 4; i++) push(PH_IDLE, 0, 0, 0, 0);
    for (int j = 2; j < exp_q.size(); j++) begin
      if (exp_q[j-2].st == PH_BIAS) begin
        e    = exp_q[j];
        e.rv = 1'b1;
        e.rk = exp_q[j-2].kidx;
        exp_q[j] = e;
      end
    end
  endfunction

  function automatic int model_index(input phase_e st);
    for (int j = 0; j < exp_q.size(); j++)
      if (exp_q[j].st == st) return j;
    return -1;
  endfunction

  function automatic int model_holds();
    int n = 0;
    for (int j = 0; j < exp_q.size(); j++)
      if (exp_q[j].st == PH_HOLD) n++;
    return n;
  endfunction

  task automatic clear_holds();
    for (int i = 0; i < MAXC; i++) hold_sched[i] = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic compare_cycle(input int c);
    cyc_t e;
    e = exp_q[c];
    check("current_state", c, 32'(bus_if.current_state), 32'(e.st));
    check("kernel_idx",    c, 32'(bus_if.kernel_idx),    32'(e.kidx));
    check("window_cnt",    c, 32'(bus_if.window_cnt),    32'(e.win));
    check("acc_clear",     c, 32'(bus_if.acc_clear),     32'(e.acc));
    check("result_valid",  c, 32'(bus_if.result_valid),  32'(e.rv));
    if (e.rv) check("result_kernel", c, 32'(bus_if.result_kernel), 32'(e.rk));
    check("done",          c, 32'(bus_if.done),          32'(e.done));
    check("busy",          c, 32'(bus_if.busy),          32'(e.busy));
  endtask

  // Pulses start, then walks the expected trace on negedges. stop_at >= 0
  // returns right after that cycle has been compared.
  task automatic run_layer(input bit start_noise, input int stop_at,
                           output int done_at, output int rv_seen,
                           output int hold_seen);
    done_at = -1; rv_seen = 0; hold_seen = 0;
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.hold_req = 1'b0;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c > 0) @(negedge clk);
      compare_cycle(c);
      if (bus_if.current_state == PH_DONE && done_at < 0) done_at = c;
      if (bus_if.result_valid === 1'b1) rv_seen++;
      if (bus_if.current_state == PH_HOLD) hold_seen++;
      if (c == stop_at) return;
      bus_if.hold_req = hold_sched[c];
      bus_if.start    = (start_noise && exp_q[c].st != PH_IDLE) ?
                        1'($urandom_range(0, 1)) : 1'b0;
    end
    bus_if.hold_req = 1'b0;
    bus_if.start    = 1'b0;
  endtask

  task automatic check_perf(input int exp_holds);
`ifdef CONV_SCHED_PERF_EN
    check("hold_cycles", 0, 32'(bus_if.hold_cycles), 32'(exp_holds));
`else
    if (exp_holds < 0) $display("unexpected negative hold count");
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int done_at, rv_seen, hold_seen, j;

    bus_if.start    = 1'b0;
    bus_if.hold_req = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 0, 32'(bus_if.current_state), 32'(PH_IDLE));
    check("reset_kidx",  0, 32'(bus_if.kernel_idx), 0);
    check("reset_win",   0, 32'(bus_if.window_cnt), 0);
    check("reset_busy",  0, 32'(bus_if.busy), 0);
    check("reset_done",  0, 32'(bus_if.done), 0);
    check("reset_rv",    0, 32'(bus_if.result_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1) No back-pressure, start noise while busy.
    clear_holds();
    build_model();
    run_layer(1'b1, -1, done_at, rv_seen, hold_seen);
    check("layer_cycles_nohold", 0, done_at, T_LAYER);
    check("result_count", 0, rv_seen, NW * KERNEL_NUM);
    check_perf(0);

    // 2) hold_req high from the last BIAS of window 3 for 8 cycles: LOAD runs
    //    unaffected, then 5 HOLD cycles before SHIFT.
    clear_holds();
    build_model();
    j = -1;
    for (int i = 0; i + 1 < exp_q.size(); i++)
      if (j < 0 && exp_q[i].st == PH_LOAD && exp_q[i].win == WW'(4) &&
          exp_q[i+1].st == PH_SHIFT) j = i;
    for (int i = j - LOAD_CYCLES; i <= j + 4; i++) hold_sched[i] = 1'b1;
    build_model();
    run_layer(1'b0, -1, done_at, rv_seen, hold_seen);
    check("layer_cycles_hold5", 0, done_at, T_LAYER + 5);
    check("hold_seen_5", 0, hold_seen, 5);
    check_perf(5);

    // 3) hold_req high across the PRELOAD end.
    clear_holds();
    for (int i = 0; i < PRELOAD_CYCLES + 2; i++) hold_sched[i] = 1'b1;
    build_model();
    run_layer(1'b0, -1, done_at, rv_seen, hold_seen);
    check("layer_cycles_preload_hold", 0, done_at, T_LAYER + 3);
    check("hold_seen_preload", 0, hold_seen, 3);

    // 4) Async reset in the middle of window 7 SHIFT.
    clear_holds();
    build_model();
    j = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (j < 0 && exp_q[i].st == PH_SHIFT && exp_q[i].win == WW'(7)) j = i + 4;
    run_layer(1'b0, j, done_at, rv_seen, hold_seen);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_state", j, 32'(bus_if.current_state), 32'(PH_IDLE));
    check("midreset_kidx",  j, 32'(bus_if.kernel_idx), 0);
    check("midreset_win",   j, 32'(bus_if.window_cnt), 0);
    check("midreset_busy",  j, 32'(bus_if.busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("postreset_state", i, 32'(bus_if.current_state), 32'(PH_IDLE));
      check("postreset_done",  i, 32'(bus_if.done), 0);
      check("postreset_rv",    i, 32'(bus_if.result_valid), 0);
    end

    // 5) Fresh full layer after the reset.
    clear_holds();
    build_model();
    run_layer(1'b1, -1, done_at, rv_seen, hold_seen);
    check("layer_cycles_after_reset", 0, done_at, T_LAYER);

    // 6) Random back-pressure.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < MAXC; i++) hold_sched[i] = ($urandom_range(0, 3) == 0);
      build_model();
      run_layer(1'b1, -1, done_at, rv_seen, hold_seen);
      check("layer_cycles_random", r, done_at, model_index(PH_DONE));
      check("hold_seen_random", r, hold_seen, model_holds());
      check_perf(model_holds());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
